// File: rtl/exp_axi4lite_slave.sv
// AXI4-Lite register front end for the modular-exponent core: CTRL/OPERAND/STATUS/RESULT
// registers plus a sequencer that sends load/start/ack pulses to the core.
module exp_axi4lite_slave #(
  parameter int C_ADDR_W = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  // write address / data / response
  input  logic [C_ADDR_W-1:0] s_axi_awaddr,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [31:0]         s_axi_wdata,
  input  logic [3:0]          s_axi_wstrb,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  // read address / data
  input  logic [C_ADDR_W-1:0] s_axi_araddr,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic [31:0]         s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready,
  // exponent core
  output logic                o_load,
  output logic                o_start,
  output logic [3:0]          o_X,
  output logic [3:0]          o_A,
  input  logic                i_done,
  input  logic [14:0]         i_P,
  output logic                o_irq
);

  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_OPERAND = 2'd1;
  localparam logic [1:0] REG_STATUS  = 2'd2;
  localparam logic [1:0] REG_RESULT  = 2'd3;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_ACK   = 3'd4;

  logic        awready_q, bvalid_q, arready_q, rvalid_q;
  logic [31:0] rdata_q;
  logic [2:0]  state_q, state_d;
  logic        ie_q, ie_d;
  logic [3:0]  x_q, x_d, a_q, a_d;
  logic        done_q, done_d;
  logic [14:0] result_q, result_d;

  logic        wr_en, rd_en, go_accept, busy;
  logic [1:0]  wr_sel, rd_sel;
  logic [31:0] rd_mux;
  logic        unused_bits;

  // Only bits [3:2] select a register; byte offset and any upper address bits are don't-care.
  assign wr_sel    = s_axi_awaddr[3:2];
  assign rd_sel    = s_axi_araddr[3:2];
  assign wr_en     = awready_q & s_axi_awvalid & s_axi_wvalid;
  assign rd_en     = arready_q & s_axi_arvalid;
  assign busy      = (state_q != S_IDLE);
  assign go_accept = wr_en & (wr_sel == REG_CTRL) & s_axi_wstrb[0] & s_axi_wdata[0] & ~busy;

  assign unused_bits = ^{s_axi_awaddr, s_axi_araddr, s_axi_wdata, s_axi_wstrb};

  // NOTE: every handshake flop is reset because the AXI reset state of valid/ready is observable.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (awready_q)                                           awready_q <= 1'b0;
      else if (s_axi_awvalid && s_axi_wvalid && !bvalid_q)     awready_q <= 1'b1;

      if (wr_en)             bvalid_q <= 1'b1;
      else if (s_axi_bready) bvalid_q <= 1'b0;

      if (arready_q)                         arready_q <= 1'b0;
      else if (s_axi_arvalid && !rvalid_q)   arready_q <= 1'b1;

      if (rd_en) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_mux;
      end else if (s_axi_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  always_comb begin
    // NOTE: default first so no path through this block leaves rd_mux unassigned (no latch).
    rd_mux = '0;
    case (rd_sel)
      REG_CTRL:    rd_mux = {30'd0, ie_q, 1'b0};
      REG_OPERAND: rd_mux = {20'd0, a_q, 4'd0, x_q};
      REG_STATUS:  rd_mux = {30'd0, done_q, busy};
      REG_RESULT:  rd_mux = {17'd0, result_q};
      default:     rd_mux = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    ie_d     = ie_q;
    x_d      = x_q;
    a_d      = a_q;
    done_d   = done_q;
    result_d = result_q;

    if (wr_en) begin
      case (wr_sel)
        REG_CTRL:    if (s_axi_wstrb[0]) ie_d = s_axi_wdata[1];
        REG_OPERAND: begin
          if (s_axi_wstrb[0]) x_d = s_axi_wdata[3:0];
          if (s_axi_wstrb[1]) a_d = s_axi_wdata[11:8];
        end
        REG_STATUS:  if (s_axi_wstrb[0] && s_axi_wdata[1]) done_d = 1'b0;
        default:     ;
      endcase
    end

    // Sequencer evaluated after the W1C so a completing operation's DONE set wins.
    case (state_q)
      S_IDLE:  if (go_accept) begin
                 state_d = S_LOAD;
                 done_d  = 1'b0;
               end
      S_LOAD:  state_d = S_START;
      S_START: state_d = S_WAIT;
      S_WAIT:  if (i_done) begin
                 result_d = i_P;
                 done_d   = 1'b1;
                 state_d  = S_ACK;
               end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      ie_q     <= 1'b0;
      x_q      <= '0;
      a_q      <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      ie_q     <= ie_d;
      x_q      <= x_d;
      a_q      <= a_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = awready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = 2'b00;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = 2'b00;

  // Core pulses decode straight from state, so they drop the instant reset asserts.
  assign o_load  = (state_q == S_LOAD);
  assign o_start = (state_q == S_START) | (state_q == S_ACK);
  assign o_X     = x_q;
  assign o_A     = a_q;
  assign o_irq   = done_q & ie_q;

endmodule

// File: tb/tb_exp_axi4lite_slave.sv
// Directed bench for exp_axi4lite_slave with a small behavioural exponent core attached.
module tb_exp_axi4lite_slave;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [3:0]  s_axi_awaddr, s_axi_araddr;
  logic        s_axi_awvalid, s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid, s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid, s_axi_bready;
  logic        s_axi_arvalid, s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid, s_axi_rready;
  logic        o_load, o_start, o_irq;
  logic [3:0]  o_X, o_A;
  logic        i_done;
  logic [14:0] i_P;

  int checks = 0;
  int failures = 0;

  exp_axi4lite_slave #(.C_ADDR_W(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .o_load(o_load), .o_start(o_start), .o_X(o_X), .o_A(o_A),
    .i_done(i_done), .i_P(i_P), .o_irq(o_irq)
  );

  always #5 i_clk = ~i_clk;

  // Behavioural core: latch on load, compute for ~10 cycles after start, hold done until the ack start.
  function automatic logic [14:0] pow15(input logic [3:0] x, input logic [3:0] a);
    logic [14:0] r;
    r = 15'd1;
    for (int i = 0; i < int'(a); i++) r = 15'(r * 15'(x));
    return r;
  endfunction

  logic [3:0] c_x, c_a, c_cnt;
  logic       c_run, c_done;
  logic [14:0] c_p;

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      c_x <= '0; c_a <= '0; c_cnt <= '0; c_run <= 1'b0; c_done <= 1'b0; c_p <= '0;
    end else begin
      if (o_load) begin c_x <= o_X; c_a <= o_A; end
      if (o_start && !c_run && !c_done) begin c_run <= 1'b1; c_cnt <= 4'd10; end
      else if (o_start && c_done) c_done <= 1'b0;
      if (c_run) begin
        if (c_cnt == 0) begin c_run <= 1'b0; c_done <= 1'b1; c_p <= pow15(c_x, c_a); end
        else c_cnt <= c_cnt - 4'd1;
      end
    end
  end
  assign i_done = c_done;
  assign i_P    = c_p;

  // Pulse monitor, sampled on the falling edge.
  int cyc = 0, load_cnt = 0, load_cyc = -1, start_cyc = -1, overlap = 0;
  bit want_start = 0;
  always @(negedge i_clk) begin
    cyc++;
    if (o_load && o_start) overlap++;
    if (o_start && want_start) begin start_cyc = cyc; want_start = 0; end
    if (o_load) begin load_cnt++; load_cyc = cyc; want_start = 1; end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk); #1;
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    int n;
    s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    n = 0;
    while (!s_axi_awready && n < 20) begin tick(); n++; end
    if (!s_axi_awready) check("aw_timeout", {31'd0, s_axi_awready}, 32'd1);
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    n = 0;
    while (!s_axi_bvalid && n < 20) begin tick(); n++; end
    if (!s_axi_bvalid) check("b_timeout", {31'd0, s_axi_bvalid}, 32'd1);
    resp = s_axi_bresp;
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
    int n;
    s_axi_araddr = addr; s_axi_arvalid = 1'b1;
    n = 0;
    while (!s_axi_arready && n < 20) begin tick(); n++; end
    if (!s_axi_arready) check("ar_timeout", {31'd0, s_axi_arready}, 32'd1);
    tick();
    s_axi_arvalid = 1'b0;
    n = 0;
    while (!s_axi_rvalid && n < 20) begin tick(); n++; end
    if (!s_axi_rvalid) check("r_timeout", {31'd0, s_axi_rvalid}, 32'd1);
    data = s_axi_rdata;
    s_axi_rready = 1'b1;
    tick();
    s_axi_rready = 1'b0;
  endtask

  task automatic wait_done();
    logic [31:0] st;
    st = '0;
    for (int i = 0; i < 40; i++) begin
      axi_read(4'h8, st);
      if (st[1]) break;
    end
    check("done_wait", {31'd0, st[1]}, 32'd1);
  endtask

  logic [1:0]  resp;
  logic [31:0] rd;
  int          l0;

  initial begin
    i_rst_n = 1'b0;
    s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
    s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; s_axi_araddr = '0; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b0;
    repeat (3) tick();
    check("rst_outs", {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready,
                       s_axi_rvalid, o_load, o_start, o_irq}, 32'd0);
    check("rst_rdata", s_axi_rdata, 32'd0);
    i_rst_n = 1'b1;
    tick();

    axi_read(4'h8, rd); check("rst_status", rd, 32'd0);
    axi_read(4'hC, rd); check("rst_result", rd, 32'd0);

    // 3^4 = 81
    axi_write(4'h4, 32'h0000_0403, 4'hF, resp);
    check("opnd_xa", {24'd0, o_A, o_X}, 32'h43);
    l0 = load_cnt;
    axi_write(4'h0, 32'h1, 4'hF, resp);
    check("go_bresp", {30'd0, resp}, 32'd0);
    wait_done();
    check("one_load", load_cnt, l0 + 1);
    check("start_after_load", start_cyc, load_cyc + 1);
    axi_read(4'hC, rd); check("res_81", rd, 32'd81);
    axi_read(4'h8, rd); check("status_done", rd, 32'h2);
    axi_read(4'h0, rd); check("go_reads0", rd, 32'd0);

    // A=0 gives 1, then 7^5 with DONE cleared by GO
    axi_write(4'h4, 32'h0000_0007, 4'hF, resp);
    axi_write(4'h0, 32'h1, 4'hF, resp);
    wait_done();
    axi_read(4'hC, rd); check("res_a0", rd, 32'd1);
    axi_write(4'h4, 32'h0000_0507, 4'hF, resp);
    axi_write(4'h0, 32'h1, 4'hF, resp);
    axi_read(4'h8, rd); check("go_clears_done", rd, 32'h1);
    wait_done();
    axi_read(4'hC, rd); check("res_16807", rd, 32'd16807);

    // GO and OPERAND writes while busy
    axi_write(4'h4, 32'h0000_0403, 4'hF, resp);
    axi_write(4'h0, 32'h1, 4'hF, resp);
    l0 = load_cnt;
    axi_write(4'h4, 32'h0000_0507, 4'hF, resp);
    axi_write(4'h0, 32'h1, 4'hF, resp);
    check("busy_go_bresp", {30'd0, resp}, 32'd0);
    wait_done();
    check("busy_go_noload", load_cnt, l0);
    axi_read(4'hC, rd); check("busy_res_81", rd, 32'd81);

    // byte strobes, RESULT read-only, unaligned address, W1C lane 0 only
    axi_write(4'h4, 32'h0000_0903, 4'h1, resp);
    axi_read(4'h4, rd); check("strb_lane0", rd, 32'h0503);
    axi_write(4'h4, 32'h0000_0C00, 4'h2, resp);
    axi_read(4'h6, rd); check("strb_lane1_unal", rd, 32'h0C03);
    axi_write(4'hC, 32'h0000_FFFF, 4'hF, resp);
    axi_read(4'hC, rd); check("result_ro", rd, 32'd81);
    axi_write(4'h8, 32'h0000_0002, 4'h2, resp);
    axi_read(4'h8, rd); check("w1c_lane1_ign", rd, 32'h2);

    // interrupt
    axi_write(4'h8, 32'h2, 4'h1, resp);
    axi_write(4'h4, 32'h0000_0403, 4'hF, resp);
    axi_write(4'h0, 32'h3, 4'hF, resp);
    check("irq_low_busy", {31'd0, o_irq}, 32'd0);
    wait_done();
    check("irq_high", {31'd0, o_irq}, 32'd1);
    axi_write(4'h8, 32'h2, 4'h1, resp);
    check("irq_cleared", {31'd0, o_irq}, 32'd0);
    axi_read(4'h8, rd); check("w1c_status", rd, 32'd0);
    axi_read(4'h0, rd); check("ctrl_ie", rd, 32'h2);

    // read stall with a second arvalid pending
    s_axi_araddr = 4'hC; s_axi_arvalid = 1'b1;
    for (int n = 0; n < 20 && !s_axi_arready; n++) tick();
    tick();
    s_axi_araddr = 4'h0;
    for (int i = 0; i < 5; i++) begin
      check("stall_rvalid", {31'd0, s_axi_rvalid}, 32'd1);
      check("stall_rdata", s_axi_rdata, 32'd81);
      check("stall_arready", {31'd0, s_axi_arready}, 32'd0);
      tick();
    end
    s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
    tick();
    s_axi_rready = 1'b0;
    check("stall_release", {31'd0, s_axi_rvalid}, 32'd0);

    // asynchronous reset during S_WAIT
    axi_write(4'h0, 32'h1, 4'hF, resp);
    repeat (4) tick();
    i_rst_n = 1'b0;
    #1;
    check("arst_outs", {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready,
                        s_axi_rvalid, o_load, o_start, o_irq}, 32'd0);
    check("arst_xa_rdata", {o_A, o_X, s_axi_rdata[23:0]}, 32'd0);
    tick();
    i_rst_n = 1'b1;
    tick();
    axi_read(4'h8, rd); check("arst_status", rd, 32'd0);
    axi_read(4'hC, rd); check("arst_result", rd, 32'd0);
    check("no_overlap", overlap, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
